// File: rtl/iob_wb_bridge.sv
// IOb-native slave to Wishbone B3 classic single-transfer master bridge.
// Define IOB_WB_TIMEOUT_EN to bound bus stalls with a TIMEOUT_W-bit counter.
module iob_wb_bridge #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 32,
    parameter int WB_ADDR_W = 10,
    parameter int TIMEOUT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [ADDR_W-1:0]    address,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [DATA_W/8-1:0]  wstrb,
    output logic [DATA_W-1:0]    rdata,
    output logic                 ready,
    output logic                 error,
    output logic                 busy,
    output logic [WB_ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W/8-1:0]  wb_sel_o,
    output logic                 wb_we_o,
    output logic [DATA_W-1:0]    wb_dat_o,
    input  logic [DATA_W-1:0]    wb_dat_i,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    input  logic                 wb_ack_i,
    input  logic                 wb_err_i
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t state;
    logic   tmo;

    // Byte-offset and upper address bits have no Wishbone counterpart.
    logic unused_addr;
    assign unused_addr = ^{address[1:0], address[ADDR_W-1:WB_ADDR_W+2]};

`ifdef IOB_WB_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    logic [TIMEOUT_W-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != BUS)
            tmo_cnt <= '0;
        else if (!wb_ack_i && !wb_err_i)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Fires on the stalled cycle whose increment would saturate the count.
    assign tmo = (state == BUS) && (tmo_cnt == TMO_LAST);
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rdata    <= '0;
            ready    <= 1'b0;
            error    <= 1'b0;
            busy     <= 1'b0;
            wb_adr_o <= '0;
            wb_sel_o <= '0;
            wb_we_o  <= 1'b0;
            wb_dat_o <= '0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        wb_adr_o <= address[WB_ADDR_W+1:2];
                        wb_sel_o <= (|wstrb) ? wstrb : '1;
                        wb_we_o  <= |wstrb;
                        wb_dat_o <= wdata;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        busy     <= 1'b1;
                        state    <= BUS;
                    end
                end
                BUS: begin
                    if (wb_err_i || (tmo && !wb_ack_i)) begin
                        rdata    <= '0;
                        error    <= 1'b1;
                        ready    <= 1'b1;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        state    <= RESP;
                    end else if (wb_ack_i) begin
                        rdata    <= wb_we_o ? '0 : wb_dat_i;
                        error    <= 1'b0;
                        ready    <= 1'b1;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    ready <= 1'b0;
                    error <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_wb_bridge.sv
// Directed bench for iob_wb_bridge; TIMEOUT_W=4 when IOB_WB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_iob_wb_bridge;

`ifdef IOB_WB_TIMEOUT_EN
    localparam int TW = 4;
`else
    localparam int TW = 8;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [12:0] address;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready, error, busy;
    logic [9:0]  wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_cyc_o, wb_stb_o;
    logic        wb_ack_i, wb_err_i;

    int checks = 0;
    int errors = 0;

    iob_wb_bridge #(.ADDR_W(13), .DATA_W(32), .WB_ADDR_W(10), .TIMEOUT_W(TW)) dut (
        .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata),
        .wstrb(wstrb), .rdata(rdata), .ready(ready), .error(error), .busy(busy),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s);
        valid = 1'b1; address = a; wdata = d; wstrb = s;
        tick();
        valid = 1'b0;
    endtask

    int  n;
    logic seen;

    initial begin
        rst = 1'b1; valid = 1'b0; address = '0; wdata = '0; wstrb = '0;
        wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_rdata", rdata, 32'h0);
        check("rst_ready", {31'b0, ready}, 32'h0);
        check("rst_error", {31'b0, error}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_cyc_stb", {30'b0, wb_cyc_o, wb_stb_o}, 32'h0);
        check("rst_wb_outs", {17'b0, wb_we_o, wb_sel_o, wb_adr_o}, 32'h0);
        check("rst_dat_o", wb_dat_o, 32'h0);

        // Write, acked in the first bus cycle
        req(13'h044, 32'hDEADBEEF, 4'hF);
        check("wr_cyc_stb", {30'b0, wb_cyc_o, wb_stb_o}, 32'h3);
        check("wr_adr", {22'b0, wb_adr_o}, 32'h011);
        check("wr_sel", {28'b0, wb_sel_o}, 32'hF);
        check("wr_we", {31'b0, wb_we_o}, 32'h1);
        check("wr_dat", wb_dat_o, 32'hDEADBEEF);
        check("wr_c1_ready", {31'b0, ready}, 32'h0);
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check("wr_c2_ready", {30'b0, ready, error}, 32'h2);
        check("wr_c2_cyc", {31'b0, wb_cyc_o}, 32'h0);
        check("wr_c2_busy", {31'b0, busy}, 32'h1);
        tick();
        check("wr_c3_idle", {30'b0, ready, busy}, 32'h0);

        // Read with 3 wait states
        req(13'h048, 32'h0, 4'h0);
        check("rd_sel", {28'b0, wb_sel_o}, 32'hF);
        check("rd_we", {31'b0, wb_we_o}, 32'h0);
        check("rd_c1_busy", {31'b0, busy}, 32'h1);
        tick(); tick();
        check("rd_c3_wait", {29'b0, wb_cyc_o, busy, ready}, 32'h6);
        tick();
        wb_ack_i = 1'b1; wb_dat_i = 32'h12345678;
        tick();
        wb_ack_i = 1'b0; wb_dat_i = 32'h0;
        check("rd_c5_ready", {29'b0, ready, error, busy}, 32'h5);
        check("rd_c5_rdata", rdata, 32'h12345678);
        tick();
        check("rd_c6_idle", {30'b0, ready, busy}, 32'h0);
        check("rd_rdata_hold", rdata, 32'h12345678);

        // Byte write terminated by ack and err together: err wins
        req(13'h100, 32'h00AA0000, 4'h4);
        check("be_sel", {28'b0, wb_sel_o}, 32'h4);
        wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'hFFFFFFFF;
        tick();
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 32'h0;
        check("be_ready_err", {30'b0, ready, error}, 32'h3);
        check("be_rdata", rdata, 32'h0);
        tick();
        check("be_err_clear", {30'b0, ready, error}, 32'h0);

        // Back-to-back with stray valids while busy
        req(13'h00C, 32'h0, 4'h0);
        valid = 1'b1; address = 13'h080;
        wb_ack_i = 1'b1; wb_dat_i = 32'hCAFEF00D;
        tick();
        wb_ack_i = 1'b0;
        check("bb1_ready", {31'b0, ready}, 32'h1);
        check("bb1_rdata", rdata, 32'hCAFEF00D);
        tick();
        valid = 1'b0;
        check("bb_no_extra", {30'b0, wb_cyc_o, busy}, 32'h0);
        req(13'h010, 32'h5A5A5A5A, 4'h3);
        check("bb2_cyc", {31'b0, wb_cyc_o}, 32'h1);
        check("bb2_adr", {22'b0, wb_adr_o}, 32'h004);
        check("bb2_sel", {28'b0, wb_sel_o}, 32'h3);
        valid = 1'b1; address = 13'h200;
        wb_ack_i = 1'b1;
        tick();
        valid = 1'b0; wb_ack_i = 1'b0;
        check("bb2_ready", {30'b0, ready, error}, 32'h2);
        check("bb2_wr_rdata", rdata, 32'h0);
        tick(); tick();
        check("bb2_no_extra", {30'b0, wb_cyc_o, busy}, 32'h0);

        // Ack in IDLE is ignored
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check("idle_ack", {29'b0, ready, busy, wb_cyc_o}, 32'h0);

        // Stalled read: timeout or indefinite wait
        req(13'h020, 32'h0, 4'h0);
        n = 0;
        while (wb_cyc_o && n < 400) begin
            n++;
            tick();
        end
`ifdef IOB_WB_TIMEOUT_EN
        check("tmo_cycles", n, 32'd15);
        check("tmo_ready_err", {30'b0, ready, error}, 32'h3);
        check("tmo_rdata", rdata, 32'h0);
        tick();
`else
        check("stall_cyc_held", n, 32'd400);
        check("stall_no_ready", {30'b0, ready, wb_cyc_o}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif
        check("stall_recovered", {30'b0, busy, wb_cyc_o}, 32'h0);

        // Reset at cycle 2 of a stalled read
        req(13'h030, 32'h0, 4'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_cyc_stb", {30'b0, wb_cyc_o, wb_stb_o}, 32'h0);
        check("rst_mid_busy", {30'b0, busy, ready}, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wb_ack_i = 1'b1;
            tick();
            seen = seen | ready;
        end
        wb_ack_i = 1'b0;
        check("rst_mid_no_ready", {31'b0, seen}, 32'h0);
        req(13'h3FC, 32'h0, 4'h0);
        check("fresh_adr", {22'b0, wb_adr_o}, 32'h0FF);
        tick();
        wb_ack_i = 1'b1; wb_dat_i = 32'h0BADF00D;
        tick();
        wb_ack_i = 1'b0;
        check("fresh_ready", {30'b0, ready, error}, 32'h2);
        check("fresh_rdata", rdata, 32'h0BADF00D);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
